rps_match_engine: RTL and testbench

Parametrised successor to the single-round rock-paper-scissors top: a best-of-N match engine for the iCEBreaker.
- Synchronises and debounces three active-high choice inputs.
- Draws the computer's move from a free-running mod-3 counter, scores each round and keeps per-side scores until one side wins the match.
- Sits between board pins (buttons/PMOD, merged and inverted in the top) and the LED/PMOD output drivers.

---
 rtl/rps_pkg.sv | 33 +++
 rtl/rps_match_engine_if.sv | 35 +++
 rtl/rps_debounce.sv | 42 ++++
 rtl/rps_match_engine.sv | 184 ++++++++++++++++++
 tb/tb_rps_match_engine.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/rps_pkg.sv
// Shared encodings for the rock-paper-scissors match engine: moves, display codes,
// FSM states and the round-winner helper.
package rps_pkg;

   typedef enum logic [1:0] {
      NONE     = 2'd0,
      ROCK     = 2'd1,
      PAPER    = 2'd2,
      SCISSORS = 2'd3
   } move_e;

   localparam logic [2:0] PERSON_WINS   = 3'b001;
   localparam logic [2:0] COMPUTER_WINS = 3'b010;
   localparam logic [2:0] TIE           = 3'b100;
   localparam logic [2:0] FLASH_A       = 3'b011;
   localparam logic [2:0] FLASH_B       = 3'b100;

   typedef enum logic [2:0] {
      StIdle,
      StResult,
      StWaitRel,
      StMatchOver,
      StClr
   } state_e;

   // True when move a defeats move b.
   function automatic logic beats(input move_e a, input move_e b);
      return ((a == ROCK) && (b == SCISSORS)) ||
             ((a == PAPER) && (b == ROCK)) ||
             ((a == SCISSORS) && (b == PAPER));
   endfunction

endpackage

// File: rtl/rps_match_engine_if.sv
// Pin-side bundle of the match engine: raw choice buttons in, display and score state out.
// Macro TIE_COUNT_EN adds the tie_count signal.
interface rps_match_engine_if #(
   parameter int unsigned ROUNDS_TO_WIN = 3
);
   localparam int unsigned SCORE_W = $clog2(ROUNDS_TO_WIN + 1);

   logic [2:0]         btn;
   logic [2:0]         result;
   logic [1:0]         person_choice;
   logic [1:0]         computer_choice;
   logic [SCORE_W-1:0] person_score;
   logic [SCORE_W-1:0] computer_score;
   logic               match_over;
`ifdef TIE_COUNT_EN
   logic [7:0]         tie_count;
`endif

   modport slave (
      input  btn,
`ifdef TIE_COUNT_EN
      output tie_count,
`endif
      output result, person_choice, computer_choice, person_score, computer_score, match_over
   );

   modport master (
      output btn,
`ifdef TIE_COUNT_EN
      input  tie_count,
`endif
      input  result, person_choice, computer_choice, person_score, computer_score, match_over
   );

endinterface

// File: rtl/rps_debounce.sv
// Single-bit 2-FF synchroniser followed by a stability debouncer: the output follows the
// synchronised input once it has differed for DEBOUNCE_CYCLES consecutive samples.
module rps_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_din,
   output logic o_dout
);
   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= i_din;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_ONE;
         end
      end
   end

   assign o_dout = r_stable;

endmodule

// File: rtl/rps_match_engine.sv
// Best-of-N rock-paper-scissors match engine: debounced presses play rounds against a
// free-running mod-3 counter until one side reaches ROUNDS_TO_WIN. Macro: TIE_COUNT_EN.
module rps_match_engine
   import rps_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 120000,
   parameter int unsigned HOLD_CYCLES     = 24000000,
   parameter int unsigned ROUNDS_TO_WIN   = 3,
   parameter int unsigned FLASH_LOG2      = 19
) (
   input logic               CLK,
   input logic               RST,
   rps_match_engine_if.slave bus
);
   localparam int unsigned SCORE_W = $clog2(ROUNDS_TO_WIN + 1);
   localparam int unsigned HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int unsigned FLASH_W = FLASH_LOG2 + 1;
   localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(ROUNDS_TO_WIN);
   localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);
   localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1);
   localparam logic [FLASH_W-1:0] FLASH_ONE = FLASH_W'(1);

   logic [2:0] w_deb;
   logic [2:0] w_rise;
   logic       w_press;
   move_e      w_pmove;
   move_e      w_cmove;

   for (genvar g = 0; g < 3; g++) begin : g_deb
      rps_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .i_clk (CLK),
         .i_rst (RST),
         .i_din (bus.btn[g]),
         .o_dout(w_deb[g])
      );
   end

   state_e             r_state,      w_state;
   logic [HOLD_W-1:0]  r_hold,       w_hold;
   logic [2:0]         r_result,     w_result;
   move_e              r_person,     w_person;
   move_e              r_computer,   w_computer;
   logic [SCORE_W-1:0] r_pscore,     w_pscore;
   logic [SCORE_W-1:0] r_cscore,     w_cscore;
   logic               r_match_over, w_match_over;
   logic [2:0]         r_deb_prev;
   logic [1:0]         r_mod3;
   logic [FLASH_W-1:0] r_flash;
`ifdef TIE_COUNT_EN
   logic [7:0]         r_ties,       w_ties;
`endif

   assign w_rise  = w_deb & ~r_deb_prev;
   assign w_press = |w_rise;
   assign w_cmove = move_e'(r_mod3 + 2'd1);

   // Simultaneous rises resolve rock > paper > scissors.
   always_comb begin
      if (w_rise[0])      w_pmove = ROCK;
      else if (w_rise[1]) w_pmove = PAPER;
      else                w_pmove = SCISSORS;
   end

   always_comb begin
      w_state      = r_state;
      w_hold       = r_hold;
      w_result     = r_result;
      w_person     = r_person;
      w_computer   = r_computer;
      w_pscore     = r_pscore;
      w_cscore     = r_cscore;
      w_match_over = r_match_over;
`ifdef TIE_COUNT_EN
      w_ties       = r_ties;
`endif
      case (r_state)
         StIdle: begin
            w_result = r_flash[FLASH_LOG2] ? FLASH_A : FLASH_B;
            if (w_press) begin
               w_state    = StResult;
               w_hold     = '0;
               w_person   = w_pmove;
               w_computer = w_cmove;
               if (w_pmove == w_cmove) begin
                  w_result = TIE;
`ifdef TIE_COUNT_EN
                  if (r_ties != 8'hFF) w_ties = r_ties + 8'd1;
`endif
               end else if (beats(w_pmove, w_cmove)) begin
                  w_result = PERSON_WINS;
                  if (r_pscore < SCORE_MAX) w_pscore = r_pscore + SCORE_ONE;
               end else begin
                  w_result = COMPUTER_WINS;
                  if (r_cscore < SCORE_MAX) w_cscore = r_cscore + SCORE_ONE;
               end
            end
         end
         StResult: begin
            if (r_hold == HOLD_LAST) begin
               if ((r_pscore == SCORE_MAX) || (r_cscore == SCORE_MAX)) begin
                  w_state      = StMatchOver;
                  w_match_over = 1'b1;
                  w_result     = (r_pscore == SCORE_MAX) ? PERSON_WINS : COMPUTER_WINS;
               end else begin
                  w_state = StWaitRel;
               end
            end else begin
               w_hold = r_hold + HOLD_ONE;
            end
         end
         StWaitRel: begin
            if (w_deb == 3'b000) w_state = StIdle;
         end
         StMatchOver: begin
            // The press only clears the match; it never plays a round.
            if (w_press) begin
               w_state      = StClr;
               w_pscore     = '0;
               w_cscore     = '0;
               w_person     = NONE;
               w_computer   = NONE;
               w_match_over = 1'b0;
`ifdef TIE_COUNT_EN
               w_ties       = '0;
`endif
            end
         end
         StClr: begin
            w_state = StWaitRel;
         end
         default: begin
            w_state = StIdle;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state      <= StIdle;
         r_hold       <= '0;
         r_result     <= '0;
         r_person     <= NONE;
         r_computer   <= NONE;
         r_pscore     <= '0;
         r_cscore     <= '0;
         r_match_over <= 1'b0;
         r_deb_prev   <= '0;
         r_mod3       <= '0;
         r_flash      <= '0;
`ifdef TIE_COUNT_EN
         r_ties       <= '0;
`endif
      end else begin
         r_state      <= w_state;
         r_hold       <= w_hold;
         r_result     <= w_result;
         r_person     <= w_person;
         r_computer   <= w_computer;
         r_pscore     <= w_pscore;
         r_cscore     <= w_cscore;
         r_match_over <= w_match_over;
         r_deb_prev   <= w_deb;
         r_mod3       <= (r_mod3 == 2'd2) ? 2'd0 : r_mod3 + 2'd1;
         r_flash      <= r_flash + FLASH_ONE;
`ifdef TIE_COUNT_EN
         r_ties       <= w_ties;
`endif
      end
   end

   assign bus.result          = r_result;
   assign bus.person_choice   = r_person;
   assign bus.computer_choice = r_computer;
   assign bus.person_score    = r_pscore;
   assign bus.computer_score  = r_cscore;
   assign bus.match_over      = r_match_over;
`ifdef TIE_COUNT_EN
   assign bus.tie_count       = r_ties;
`endif

endmodule

// File: tb/tb_rps_match_engine.sv
// Directed bench for rps_match_engine with short debounce/hold timing; computer moves are
// steered by a cycle counter that tracks the engine's free-running mod-3 counter.
module tb_rps_match_engine;

   logic        CLK = 1'b0;
   logic        RST;
   int unsigned n;
   int          total = 0;
   int          bad   = 0;

   rps_match_engine_if #(.ROUNDS_TO_WIN(2)) bus ();

   rps_match_engine #(
      .DEBOUNCE_CYCLES(4),
      .HOLD_CYCLES    (16),
      .ROUNDS_TO_WIN  (2),
      .FLASH_LOG2     (3)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   always #5 CLK = ~CLK;

   // Edges since reset release; the engine's mod-3 and flash counters follow it exactly.
   always @(posedge CLK or posedge RST) begin
      if (RST) n <= 0;
      else     n <= n + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int k);
      repeat (k) @(negedge CLK);
   endtask

   // Raise buttons so the press samples mod-3 value m (computer move m+1).
   task automatic raise_at(input logic [2:0] b, input int unsigned m);
      for (int i = 0; i < 3; i++) begin
         if (n % 3 != m) @(negedge CLK);
      end
      bus.btn = b;
   endtask

   function automatic logic [31:0] flash_exp();
      return ((((n - 1) >> 3) & 1) != 0) ? 32'h3 : 32'h4;
   endfunction

   initial begin
      bus.btn = 3'b000;
      RST     = 1'b1;
      step(3);
      check("rst_result", bus.result, 0);
      check("rst_pc", bus.person_choice, 0);
      check("rst_cc", bus.computer_choice, 0);
      check("rst_ps", bus.person_score, 0);
      check("rst_mo", bus.match_over, 0);
      RST = 1'b0;

      for (int i = 0; i < 32; i++) begin
         step(1);
         check("idle_flash", bus.result, flash_exp());
      end
      check("idle_ps", bus.person_score, 0);
      check("idle_cs", bus.computer_score, 0);
      check("idle_mo", bus.match_over, 0);

      // Two-cycle glitch must not be accepted.
      bus.btn = 3'b001;
      step(2);
      bus.btn = 3'b000;
      step(12);
      check("glitch_pc", bus.person_choice, 0);
      check("glitch_flash", bus.result, flash_exp());

      // Rock vs paper: computer wins, exactly 7 cycles after the rise.
      raise_at(3'b001, 1);
      step(6);
      check("lat_early_pc", bus.person_choice, 0);
      step(1);
      check("r1_pc", bus.person_choice, 1);
      check("r1_cc", bus.computer_choice, 2);
      check("r1_result", bus.result, 3'b010);
      check("r1_cs", bus.computer_score, 1);
      check("r1_ps", bus.person_score, 0);
      step(30);
      check("held_result", bus.result, 3'b010);
      check("held_cs", bus.computer_score, 1);
      bus.btn = 3'b000;
      step(10);
      check("rel_flash", bus.result, flash_exp());
      check("rel_cs", bus.computer_score, 1);
      check("rel_ps", bus.person_score, 0);

      // Rock and scissors together: rock takes priority, beats computer scissors.
      raise_at(3'b101, 2);
      step(7);
      check("r2_pc", bus.person_choice, 1);
      check("r2_cc", bus.computer_choice, 3);
      check("r2_result", bus.result, 3'b001);
      check("r2_ps", bus.person_score, 1);
      bus.btn = 3'b000;
      step(30);

      // Scissors vs scissors: tie leaves scores alone.
      raise_at(3'b100, 2);
      step(7);
      check("tie_pc", bus.person_choice, 3);
      check("tie_cc", bus.computer_choice, 3);
      check("tie_result", bus.result, 3'b100);
      check("tie_ps", bus.person_score, 1);
      check("tie_cs", bus.computer_score, 1);
      bus.btn = 3'b000;
      step(30);

      // Paper vs rock wins the match; a press during RESULT is ignored.
      raise_at(3'b010, 0);
      step(7);
      check("r3_cc", bus.computer_choice, 1);
      check("r3_result", bus.result, 3'b001);
      check("r3_ps", bus.person_score, 2);
      bus.btn = 3'b000;
      step(4);
      bus.btn = 3'b001;
      step(8);
      bus.btn = 3'b000;
      step(30);
      check("mo_flag", bus.match_over, 1);
      check("mo_result", bus.result, 3'b001);
      check("mo_ps", bus.person_score, 2);
      check("mo_cs", bus.computer_score, 1);
      check("mo_pc", bus.person_choice, 2);
      step(8);
      check("mo_steady", bus.result, 3'b001);

      // Press after match clears without playing a round.
      bus.btn = 3'b001;
      step(7);
      check("clr_mo", bus.match_over, 0);
      check("clr_ps", bus.person_score, 0);
      check("clr_cs", bus.computer_score, 0);
      check("clr_pc", bus.person_choice, 0);
      check("clr_cc", bus.computer_choice, 0);
      bus.btn = 3'b000;
      step(30);
      check("post_clr_flash", bus.result, flash_exp());
      check("post_clr_pc", bus.person_choice, 0);
      check("post_clr_ps", bus.person_score, 0);

      // Asynchronous reset in the middle of RESULT.
      raise_at(3'b001, 1);
      step(7);
      check("pre_rst_cs", bus.computer_score, 1);
      step(3);
      RST     = 1'b1;
      bus.btn = 3'b000;
      #1;
      check("arst_result", bus.result, 0);
      check("arst_cs", bus.computer_score, 0);
      check("arst_pc", bus.person_choice, 0);
      check("arst_cc", bus.computer_choice, 0);
      check("arst_mo", bus.match_over, 0);
      step(2);
      RST = 1'b0;
      step(10);
      check("after_rst_flash", bus.result, flash_exp());

`ifdef TIE_COUNT_EN
      check("tc_reset", bus.tie_count, 0);
      raise_at(3'b001, 0);
      step(7);
      bus.btn = 3'b000;
      step(30);
      raise_at(3'b010, 1);
      step(7);
      bus.btn = 3'b000;
      step(30);
      raise_at(3'b100, 2);
      step(7);
      bus.btn = 3'b000;
      step(30);
      check("tc_three", bus.tie_count, 3);
      check("tc_ps", bus.person_score, 0);
      for (int i = 0; i < 2; i++) begin
         raise_at(3'b001, 2);
         step(7);
         bus.btn = 3'b000;
         step(30);
      end
      check("tc_mo", bus.match_over, 1);
      check("tc_kept", bus.tie_count, 3);
      bus.btn = 3'b001;
      step(7);
      check("tc_clr", bus.tie_count, 0);
      bus.btn = 3'b000;
      step(30);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
